// File: rtl/da_pkg.sv
// Shared constants and FSM state encoding for the distributed-arithmetic FIR sequencer.
package da_pkg;
   localparam int SAMPLE_W       = 16;
   localparam int N_BANKS        = 8;
   localparam int TAPS_PER_BANK  = 8;
   localparam int N_TAPS         = N_BANKS * TAPS_PER_BANK;
   localparam int ACC_W          = 39;
   localparam int COEF_W         = 20;
   localparam int CADDR_W        = 11;
   localparam int BIT_IDX_W      = $clog2(SAMPLE_W);
   localparam int WAIT_LIMIT_DEF = 64;

   typedef enum logic [2:0] {
      IDLE, CFG_WR, CFG_GAP, CLR, START, WAIT, SETTLE, CAPTURE
   } state_e;
endpackage

// File: rtl/da_sequencer_if.sv
// Sample, coefficient-write and result channels between a host and da_sequencer.
interface da_sequencer_if;
   import da_pkg::*;

   // A transfer happens on a rising clk edge where valid and ready are both high.
   // The producer holds valid and payload stable until that edge; ready may depend
   // combinationally on the other side's valid, never the reverse.
   logic                s_valid;
   logic                s_ready;
   logic [SAMPLE_W-1:0] s_data;
   logic                cfg_valid;
   logic                cfg_ready;
   logic [CADDR_W-1:0]  cfg_addr;
   logic [COEF_W-1:0]   cfg_data;
   logic                y_valid;
   logic                y_ready;
   logic [ACC_W-1:0]    y_data;

   modport master (
      output s_valid, s_data, cfg_valid, cfg_addr, cfg_data, y_ready,
      input  s_ready, cfg_ready, y_valid, y_data
   );

   modport slave (
      input  s_valid, s_data, cfg_valid, cfg_addr, cfg_data, y_ready,
      output s_ready, cfg_ready, y_valid, y_data
   );
endinterface

// File: rtl/da_bitslicer.sv
// 64-tap sample delay line; presents one bit plane of all taps as bank addresses.
module da_bitslicer
   import da_pkg::*;
(
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 shift_en,
   input  logic [SAMPLE_W-1:0]  sample,
   input  logic [BIT_IDX_W-1:0] bit_sel,
   output logic [N_TAPS-1:0]    addr_vec
);
   localparam logic [BIT_IDX_W-1:0] TOP_BIT = BIT_IDX_W'(SAMPLE_W - 1);

   logic [SAMPLE_W-1:0]  dl_q [N_TAPS];
   logic [BIT_IDX_W-1:0] bit_pos;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int n = 0; n < N_TAPS; n++) dl_q[n] <= '0;
      end else if (shift_en) begin
         dl_q[0] <= sample;
         for (int n = 1; n < N_TAPS; n++) dl_q[n] <= dl_q[n-1];
      end
   end

   // Iteration 0 walks the sign bit, so the bit plane is counted down from the MSB.
   assign bit_pos = TOP_BIT - bit_sel;

   always_comb begin
      addr_vec = '0;
      for (int n = 0; n < N_TAPS; n++) addr_vec[n] = dl_q[n][bit_pos];
   end
endmodule

// File: rtl/da_sequencer.sv
// Sample-level scheduler for the DA FIR datapath: coefficient loads, 16 bit-serial
// iterations per sample with a done timeout, and a one-entry result buffer.
module da_sequencer
   import da_pkg::*;
#(
   parameter int WAIT_LIMIT = WAIT_LIMIT_DEF
) (
   input  logic               clk,
   input  logic               resetn,
   da_sequencer_if.slave      bus,
   output logic               busy,
   output logic               err_timeout,
   output logic [N_TAPS-1:0]  da_addr,
   output logic [COEF_W-1:0]  da_cin,
   output logic [CADDR_W-1:0] da_caddr,
   output logic               da_cload,
   output logic               da_start,
   output logic               da_reset,
   input  logic               da_done,
   input  logic [ACC_W-1:0]   da_acc_out,
   output state_e             dbg_state
);
   localparam int                   WCNT_W    = $clog2(WAIT_LIMIT + 1);
   localparam logic [WCNT_W-1:0]    WAIT_LAST = WCNT_W'(WAIT_LIMIT - 1);
   localparam logic [BIT_IDX_W-1:0] LAST_BIT  = BIT_IDX_W'(SAMPLE_W - 1);

   state_e               state_q, state_d;
   logic                 live_q;
   logic [BIT_IDX_W-1:0] bit_idx_q, bit_sel;
   logic [WCNT_W-1:0]    wait_cnt_q;
   logic [N_TAPS-1:0]    slice_vec;
   logic                 cfg_acc, s_acc, last_bit, iter_done, timed_out, y_load;

   // live_q keeps both ready outputs low while reset is asserted.
   assign bus.cfg_ready = live_q && (state_q == IDLE);
   assign bus.s_ready   = live_q && (state_q == IDLE) && !bus.cfg_valid;
   assign cfg_acc       = bus.cfg_ready && bus.cfg_valid;
   assign s_acc         = bus.s_ready && bus.s_valid;
   assign last_bit      = (bit_idx_q == LAST_BIT);
   assign iter_done     = (state_q == WAIT) && da_done;
   assign timed_out     = (state_q == WAIT) && !da_done && (wait_cnt_q == WAIT_LAST);
   assign y_load        = (state_q == CAPTURE) && (!bus.y_valid || bus.y_ready);
   assign bit_sel       = (state_q == CLR) ? '0 : bit_idx_q + BIT_IDX_W'(1);

   assign da_cload  = (state_q == CFG_WR);
   assign da_start  = (state_q == START);
   assign da_reset  = (state_q == CLR);
   assign busy      = (state_q != IDLE);
   assign dbg_state = state_q;

   da_bitslicer u_slicer (
      .clk      (clk),
      .resetn   (resetn),
      .shift_en (s_acc),
      .sample   (bus.s_data),
      .bit_sel  (bit_sel),
      .addr_vec (slice_vec)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (cfg_acc)    state_d = CFG_WR;
            else if (s_acc) state_d = CLR;
         end
         CFG_WR:  state_d = CFG_GAP;
         CFG_GAP: state_d = IDLE;
         CLR:     state_d = START;
         START:   state_d = WAIT;
         WAIT: begin
            if (iter_done)      state_d = last_bit ? SETTLE : START;
            else if (timed_out) state_d = IDLE;
         end
         SETTLE:  state_d = CAPTURE;
         CAPTURE: if (y_load) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         live_q      <= 1'b0;
         bit_idx_q   <= '0;
         wait_cnt_q  <= '0;
         da_addr     <= '0;
         da_caddr    <= '0;
         da_cin      <= '0;
         err_timeout <= 1'b0;
         bus.y_valid <= 1'b0;
         bus.y_data  <= '0;
      end else begin
         live_q <= 1'b1;
         if (cfg_acc) begin
            da_caddr <= bus.cfg_addr;
            da_cin   <= bus.cfg_data;
         end
         // Bank addresses only move at CLR or on an accepted done, so they stay
         // constant for the whole START/WAIT window of each iteration.
         if (state_q == CLR) begin
            bit_idx_q <= '0;
            da_addr   <= slice_vec;
         end else if (iter_done && !last_bit) begin
            bit_idx_q <= bit_sel;
            da_addr   <= slice_vec;
         end
         if (state_q == START)     wait_cnt_q <= WCNT_W'(1);
         else if (state_q == WAIT) wait_cnt_q <= wait_cnt_q + WCNT_W'(1);
         if (timed_out) err_timeout <= 1'b1;
         if (y_load) begin
            bus.y_valid <= 1'b1;
            bus.y_data  <= da_acc_out;
         end else if (bus.y_ready) begin
            bus.y_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_da_sequencer.sv
// Bench for da_sequencer: a behavioural DA datapath, randomized traffic, and a
// scoreboard fed from a weighted-bit-plane reference model of the filter output.
module tb_da_sequencer;
   import da_pkg::*;

   localparam int WAIT_LIMIT = 64;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   da_sequencer_if bus();
   logic                busy, err_timeout, da_cload, da_start, da_reset, da_done;
   logic [N_TAPS-1:0]   da_addr;
   logic [COEF_W-1:0]   da_cin;
   logic [CADDR_W-1:0]  da_caddr;
   logic [ACC_W-1:0]    da_acc_out;
   state_e              dbg_state;

   da_sequencer #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .bus        (bus),
      .busy       (busy),
      .err_timeout(err_timeout),
      .da_addr    (da_addr),
      .da_cin     (da_cin),
      .da_caddr   (da_caddr),
      .da_cload   (da_cload),
      .da_start   (da_start),
      .da_reset   (da_reset),
      .da_done    (da_done),
      .da_acc_out (da_acc_out),
      .dbg_state  (dbg_state)
   );

   int checks = 0;
   int errors = 0;
   logic [ACC_W-1:0] exp_q[$];

   // Reference state: coefficient tables as programmed, and the sample history.
   longint          ref_tab [N_BANKS][256];
   logic [15:0]     hist [N_TAPS];
   bit              rand_ready = 1'b0;

   // Behavioural DA datapath.
   logic signed [COEF_W-1:0] da_tab [N_BANKS][256];
   longint da_acc = 0;
   longint da_pend = 0;
   int     da_cnt = 0;
   int     da_bidx = 0;
   bit     da_hang = 1'b0;
   assign da_acc_out = da_acc[ACC_W-1:0];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: bound expired", name);
   endtask

   function automatic longint bank_sum(input logic [N_TAPS-1:0] a);
      longint s = 0;
      for (int k = 0; k < N_BANKS; k++) s += longint'($signed(da_tab[k][a[8*k +: 8]]));
      return s;
   endfunction

   // y = sum over bit planes of (plane weight) * (sum of bank lookups), sign plane negative.
   function automatic longint ref_y();
      longint total = 0;
      for (int i = 0; i < SAMPLE_W; i++) begin
         int b = SAMPLE_W - 1 - i;
         longint w = (i == 0) ? -(longint'(1) <<< b) : (longint'(1) <<< b);
         for (int k = 0; k < N_BANKS; k++) begin
            logic [7:0] a;
            for (int j = 0; j < TAPS_PER_BANK; j++) a[j] = hist[8*k+j][b];
            total += w * ref_tab[k][a];
         end
      end
      return total;
   endfunction

   initial begin
      for (int k = 0; k < N_BANKS; k++)
         for (int e = 0; e < 256; e++) begin
            da_tab[k][e]  = '0;
            ref_tab[k][e] = 0;
         end
      for (int t = 0; t < N_TAPS; t++) hist[t] = '0;
      da_done = 1'b0;
   end

   always @(negedge clk) begin
      if (!resetn) begin
         da_cnt  = 0;
         da_done = 1'b0;
      end else begin
         if (da_done) begin
            da_done = 1'b0;
            da_acc  = 2 * da_acc + ((da_bidx == 0) ? -da_pend : da_pend);
            da_bidx++;
         end
         if (da_cload) da_tab[da_caddr[10:8]][da_caddr[7:0]] = da_cin;
         if (da_reset) begin
            da_acc  = 0;
            da_bidx = 0;
            da_cnt  = 0;
         end
         if (da_start) begin
            da_pend = bank_sum(da_addr);
            if (!da_hang) da_cnt = $urandom_range(1, 3);
         end else if (da_cnt > 0) begin
            da_cnt--;
            if (da_cnt == 0) da_done = 1'b1;
         end
      end
   end

   // Monitor: pops on each result handshake and watches held results for stability.
   logic [ACC_W-1:0] held_y;
   bit               held = 1'b0;
   always @(negedge clk) begin
      if (!resetn) begin
         held = 1'b0;
      end else begin
         if (held) begin
            check("y_hold_valid", bus.y_valid, 1);
            check("y_hold_data", bus.y_data, held_y);
         end
         held = 1'b0;
         if (bus.y_valid && bus.y_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL y_unexpected: got 0x%0h expected no result", bus.y_data);
            end else begin
               check("y_data", bus.y_data, exp_q.pop_front());
            end
         end else if (bus.y_valid) begin
            held   = 1'b1;
            held_y = bus.y_data;
         end
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (rand_ready) bus.y_ready = 1'($urandom_range(0, 1));
   end

   task automatic send_cfg(input logic [10:0] a, input logic [19:0] d);
      int n = 0;
      @(posedge clk); #1;
      bus.cfg_valid = 1'b1; bus.cfg_addr = a; bus.cfg_data = d;
      @(negedge clk);
      while (!bus.cfg_ready && n < 5000) begin @(negedge clk); n++; end
      if (!bus.cfg_ready) begin fail("cfg_accept"); bus.cfg_valid = 1'b0; return; end
      @(posedge clk); #1;
      bus.cfg_valid = 1'b0;
      ref_tab[a[10:8]][a[7:0]] = longint'($signed(d));
   endtask

   task automatic record_sample(input logic [15:0] d, input bit expect_y);
      for (int t = N_TAPS - 1; t > 0; t--) hist[t] = hist[t-1];
      hist[0] = d;
      if (expect_y) exp_q.push_back(ACC_W'(ref_y()));
   endtask

   task automatic send_sample(input logic [15:0] d, input bit expect_y);
      int n = 0;
      @(posedge clk); #1;
      bus.s_valid = 1'b1; bus.s_data = d;
      @(negedge clk);
      while (!bus.s_ready && n < 5000) begin @(negedge clk); n++; end
      if (!bus.s_ready) begin fail("s_accept"); bus.s_valid = 1'b0; return; end
      @(posedge clk); #1;
      bus.s_valid = 1'b0;
      record_sample(d, expect_y);
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || busy || bus.y_valid) && n < 5000) begin
         @(negedge clk); n++;
      end
      if (n >= 5000) fail("drain");
   endtask

   task automatic reset_pulse();
      @(negedge clk); #2 resetn = 1'b0;
      for (int t = 0; t < N_TAPS; t++) hist[t] = '0;
      repeat (2) @(negedge clk);
      #2 resetn = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_s_ready"}, bus.s_ready, 0);
      check({tag, "_cfg_ready"}, bus.cfg_ready, 0);
      check({tag, "_y_valid"}, bus.y_valid, 0);
      check({tag, "_y_data"}, bus.y_data, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_err_timeout"}, err_timeout, 0);
      check({tag, "_da_addr"}, da_addr, 0);
      check({tag, "_da_cin"}, da_cin, 0);
      check({tag, "_da_caddr"}, da_caddr, 0);
      check({tag, "_da_cload"}, da_cload, 0);
      check({tag, "_da_start"}, da_start, 0);
      check({tag, "_da_reset"}, da_reset, 0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int starts;
      int n;
      bus.s_valid = 1'b0; bus.s_data = '0;
      bus.cfg_valid = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
      bus.y_ready = 1'b1;

      repeat (3) @(negedge clk);
      check_all_zero("rst");
      #2 resetn = 1'b1;
      repeat (2) @(negedge clk);

      // Single coefficient: tap0 alone weighs 16.
      send_cfg(11'h001, 20'h00010);
      send_sample(16'h0003, 1);
      send_sample(16'h0000, 1);
      drain();

      // Sign handling from an empty delay line.
      reset_pulse();
      send_sample(16'hFFFF, 1);
      drain();
      reset_pulse();
      send_sample(16'h8000, 1);
      drain();

      // Simultaneous cfg and sample: the write goes first.
      @(posedge clk); #1;
      bus.cfg_valid = 1'b1; bus.cfg_addr = 11'h0FF; bus.cfg_data = 20'h00123;
      bus.s_valid = 1'b1;   bus.s_data = 16'h0005;
      @(negedge clk);
      check("arb_cfg_ready", bus.cfg_ready, 1);
      check("arb_s_blocked", bus.s_ready, 0);
      @(posedge clk); #1;
      bus.cfg_valid = 1'b0;
      ref_tab[0][8'hFF] = longint'($signed(20'h00123));
      @(negedge clk);
      check("arb_cload_on", da_cload, 1);
      check("arb_caddr", da_caddr, 11'h0FF);
      check("arb_cin", da_cin, 20'h00123);
      check("arb_s_wait1", bus.s_ready, 0);
      @(negedge clk);
      check("arb_cload_off", da_cload, 0);
      check("arb_s_wait2", bus.s_ready, 0);
      @(negedge clk);
      check("arb_s_ready", bus.s_ready, 1);
      @(posedge clk); #1;
      bus.s_valid = 1'b0;
      record_sample(16'h0005, 1);
      drain();

      // Backpressure: two results, the second parks in CAPTURE.
      @(posedge clk); #1 bus.y_ready = 1'b0;
      send_sample(16'($urandom), 1);
      send_sample(16'($urandom), 1);
      n = 0;
      while (dbg_state != CAPTURE && n < 1000) begin @(negedge clk); n++; end
      if (n >= 1000) fail("bp_reach_capture");
      repeat (5) @(negedge clk);
      check("bp_stall_state", dbg_state, CAPTURE);
      check("bp_y_valid", bus.y_valid, 1);
      check("bp_first_held", bus.y_data, exp_q[0]);
      @(posedge clk); #1 bus.y_ready = 1'b1;
      drain();
      check("bp_queue_empty", exp_q.size(), 0);

      // Asynchronous reset in WAIT at iteration 7.
      send_sample(16'h1234, 0);
      starts = 0;
      n = 0;
      while (starts < 8 && n < 2000) begin
         @(negedge clk); n++;
         if (da_start) starts++;
      end
      if (starts < 8) fail("ar_reach_iter7");
      @(negedge clk);
      check("ar_in_wait", dbg_state, WAIT);
      #2 resetn = 1'b0;
      #1;
      check_all_zero("ar");
      for (int t = 0; t < N_TAPS; t++) hist[t] = '0;
      repeat (2) @(negedge clk);
      #2 resetn = 1'b1;
      repeat (2) @(negedge clk);
      send_sample(16'h0003, 1);
      drain();

      // Timeout: the datapath never answers.
      da_hang = 1'b1;
      send_sample(16'h0007, 0);
      n = 0;
      while (!da_start && n < 20) begin @(negedge clk); n++; end
      if (!da_start) fail("to_start");
      repeat (WAIT_LIMIT - 1) @(negedge clk);
      check("to_err_before", err_timeout, 0);
      check("to_busy_before", busy, 1);
      @(negedge clk);
      check("to_err_set", err_timeout, 1);
      check("to_idle", busy, 0);
      da_hang = 1'b0;
      repeat (5) @(negedge clk);
      check("to_no_y", bus.y_valid, 0);
      send_sample(16'h0002, 1);
      drain();
      check("to_err_sticky", err_timeout, 1);

      // Randomized traffic with random result backpressure.
      rand_ready = 1'b1;
      for (int k = 0; k < 60; k++) begin
         if ($urandom_range(0, 2) == 0) send_cfg(11'($urandom), 20'($urandom));
         else                           send_sample(16'($urandom), 1);
      end
      drain();
      rand_ready = 1'b0;
      @(posedge clk); #1 bus.y_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("end_queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
